// File: rtl/coordinates.sv
// Widths of scan counters and screen coordinates, plus the animator FSM states.
package coordinates;
    localparam int CX  = 10;
    localparam int CY  = 10;
    localparam int SCX = 10;
    localparam int SCY = 9;

    typedef logic [SCX-1:0]         scx_t;
    typedef logic [SCY-1:0]         scy_t;
    typedef logic signed [7:0]      vel_t;
    typedef logic signed [SCX+7:0]  prod_t;

    typedef enum logic [2:0] {
        IDLE,
        MOVE,
        MUL_C,
        MUL_S,
        CORNERS,
        COMMIT
    } state_e;
endpackage

// File: rtl/vga_c.sv
// Display geometry shared by the VGA timing block and everything drawn on it.
package vga_c;
    localparam int HRES = 640;
    localparam int VRES = 480;
endpackage

// File: rtl/quad_anim_if.sv
// Scan position in, pause control, and the four registered corners out to the surface.
interface quad_anim_if;
    import coordinates::*;

    logic [CX-1:0] h_count;
    logic [CY-1:0] v_count;
    logic          pause;
    scx_t          pointax, pointbx, pointcx, pointdx;
    scy_t          pointay, pointby, pointcy, pointdy;
    logic          busy;
    logic          frame_done;

    modport master (
        output h_count, v_count, pause,
        input  pointax, pointbx, pointcx, pointdx,
        input  pointay, pointby, pointcy, pointdy,
        input  busy, frame_done
    );

    modport slave (
        input  h_count, v_count, pause,
        output pointax, pointbx, pointcx, pointdx,
        output pointay, pointby, pointcy, pointdy,
        output busy, frame_done
    );
endinterface

// File: rtl/quad_trig_lut.sv
// 16-step rotation table: round(64*cos) and round(64*sin) of phase*22.5 degrees.
module quad_trig_lut (
    input  logic [3:0]        phase,
    output logic signed [7:0] cos_q,
    output logic signed [7:0] sin_q
);
    // NOTE: both outputs get a default before the case so no path infers a latch.
    always_comb begin
        cos_q = 8'sd0;
        sin_q = 8'sd0;
        case (phase)
            4'd0:  begin cos_q =  8'sd64; sin_q =  8'sd0;  end
            4'd1:  begin cos_q =  8'sd59; sin_q =  8'sd24; end
            4'd2:  begin cos_q =  8'sd45; sin_q =  8'sd45; end
            4'd3:  begin cos_q =  8'sd24; sin_q =  8'sd59; end
            4'd4:  begin cos_q =  8'sd0;  sin_q =  8'sd64; end
            4'd5:  begin cos_q = -8'sd24; sin_q =  8'sd59; end
            4'd6:  begin cos_q = -8'sd45; sin_q =  8'sd45; end
            4'd7:  begin cos_q = -8'sd59; sin_q =  8'sd24; end
            4'd8:  begin cos_q = -8'sd64; sin_q =  8'sd0;  end
            4'd9:  begin cos_q = -8'sd59; sin_q = -8'sd24; end
            4'd10: begin cos_q = -8'sd45; sin_q = -8'sd45; end
            4'd11: begin cos_q = -8'sd24; sin_q = -8'sd59; end
            4'd12: begin cos_q =  8'sd0;  sin_q = -8'sd64; end
            4'd13: begin cos_q =  8'sd24; sin_q = -8'sd59; end
            4'd14: begin cos_q =  8'sd45; sin_q = -8'sd45; end
            default: begin cos_q = 8'sd59; sin_q = -8'sd24; end
        endcase
    end
endmodule

// File: rtl/quad_anim.sv
// Bouncing, rotating square: once per frame, in vertical blanking, moves the centre,
// steps the rotation phase and recomputes the four corners with one shared multiplier.
module quad_anim #(
    parameter int unsigned HALF = 24,
    parameter int          VX0  = 2,
    parameter int          VY0  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    quad_anim_if.slave  bus
);
    import vga_c::*;
    import coordinates::*;

    localparam int    M      = int'(HALF) + int'(HALF) / 2;
    localparam prod_t X_MAX  = prod_t'(HRES - 1 - M);
    localparam prod_t Y_MAX  = prod_t'(VRES - 1 - M);
    localparam prod_t LO_LIM = prod_t'(M);
    localparam prod_t HALF_S = prod_t'(HALF);
    localparam scx_t  CX0    = scx_t'(HRES / 2);
    localparam scy_t  CY0    = scy_t'(VRES / 2);
    localparam scx_t  HX     = scx_t'(HALF);
    localparam scy_t  HY     = scy_t'(HALF);

    state_e       state_q;
    scx_t         cx_q, cx_d;
    scy_t         cy_q, cy_d;
    vel_t         vx_q, vx_d, vy_q, vy_d;
    logic [3:0]   phase_q;
    prod_t        p_q, q_q, dx_q, dy_q, dx_d, dy_d;
    prod_t        cxs, cys, nx, ny, mul_op, prod;
    logic signed [7:0] cos_q, sin_q;
    scx_t         pax_q, pbx_q, pcx_q, pdx_q;
    scy_t         pay_q, pby_q, pcy_q, pdy_q;
    logic         busy_q, frame_done_q;
    logic         tick;

    quad_trig_lut u_lut (
        .phase (phase_q),
        .cos_q (cos_q),
        .sin_q (sin_q)
    );

    // First line of vertical blanking, once per frame.
    assign tick = (bus.h_count == '0) && (bus.v_count == CY'(VRES));

    always_comb begin
        cxs  = prod_t'(cx_q);
        cys  = prod_t'(cy_q);
        nx   = cxs + prod_t'(vx_q);
        ny   = cys + prod_t'(vy_q);
        cx_d = scx_t'(nx);
        vx_d = vx_q;
        cy_d = scy_t'(ny);
        vy_d = vy_q;
        if (nx > X_MAX) begin
            cx_d = scx_t'(X_MAX);
            vx_d = -vx_q;
        end else if (nx < LO_LIM) begin
            cx_d = scx_t'(LO_LIM);
            vx_d = -vx_q;
        end
        if (ny > Y_MAX) begin
            cy_d = scy_t'(Y_MAX);
            vy_d = -vy_q;
        end else if (ny < LO_LIM) begin
            cy_d = scy_t'(LO_LIM);
            vy_d = -vy_q;
        end
        mul_op = (state_q == MUL_C) ? prod_t'(cos_q) : prod_t'(sin_q);
        prod   = HALF_S * mul_op;
        dx_d   = (q_q - p_q) >>> 6;
        dy_d   = (-q_q - p_q) >>> 6;
    end

    // NOTE: every register here uses <= so all of them sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            cx_q         <= CX0;
            cy_q         <= CY0;
            vx_q         <= vel_t'(VX0);
            vy_q         <= vel_t'(VY0);
            phase_q      <= 4'd0;
            p_q          <= '0;
            q_q          <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            pax_q        <= CX0 - HX;  pay_q <= CY0 - HY;
            pbx_q        <= CX0 - HX;  pby_q <= CY0 + HY;
            pcx_q        <= CX0 + HX;  pcy_q <= CY0 + HY;
            pdx_q        <= CX0 + HX;  pdy_q <= CY0 - HY;
        end else begin
            frame_done_q <= 1'b0;
            // pause stalls the sequence wherever it is, so nothing commits while it is high.
            if (!bus.pause) begin
                case (state_q)
                    IDLE: if (tick) begin
                        state_q <= MOVE;
                        busy_q  <= 1'b1;
                    end
                    MOVE: begin
                        cx_q    <= cx_d;
                        cy_q    <= cy_d;
                        vx_q    <= vx_d;
                        vy_q    <= vy_d;
                        phase_q <= phase_q + 4'd1;
                        state_q <= MUL_C;
                    end
                    MUL_C: begin
                        p_q     <= prod;
                        state_q <= MUL_S;
                    end
                    MUL_S: begin
                        q_q     <= prod;
                        state_q <= CORNERS;
                    end
                    CORNERS: begin
                        dx_q    <= dx_d;
                        dy_q    <= dy_d;
                        state_q <= COMMIT;
                    end
                    COMMIT: begin
                        pax_q        <= scx_t'(cxs + dx_q);
                        pay_q        <= scy_t'(cys + dy_q);
                        pbx_q        <= scx_t'(cxs + dy_q);
                        pby_q        <= scy_t'(cys - dx_q);
                        pcx_q        <= scx_t'(cxs - dx_q);
                        pcy_q        <= scy_t'(cys - dy_q);
                        pdx_q        <= scx_t'(cxs - dy_q);
                        pdy_q        <= scy_t'(cys + dx_q);
                        frame_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.pointax    = pax_q;
    assign bus.pointay    = pay_q;
    assign bus.pointbx    = pbx_q;
    assign bus.pointby    = pby_q;
    assign bus.pointcx    = pcx_q;
    assign bus.pointcy    = pcy_q;
    assign bus.pointdx    = pdx_q;
    assign bus.pointdy    = pdy_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_quad_anim.sv
// Scoreboard bench for quad_anim: ticks are driven directly on the scan inputs and each
// committed frame is compared against a reference model of the bounce/rotate rules.
module tb_quad_anim;
    localparam int HALF = 24;
    localparam int M    = HALF + HALF / 2;
    localparam int H    = 640;
    localparam int V    = 480;

    typedef struct {
        int ax, ay, bx, by, cx, cy, dx, dy;
    } corners_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    corners_t exp_q[$];
    corners_t last_exp;
    int mcx, mcy, mvx, mvy, mph;
    int cos_t[16] = '{64, 59, 45, 24, 0, -24, -45, -59, -64, -59, -45, -24, 0, 24, 45, 59};
    int sin_t[16] = '{0, 24, 45, 59, 64, 59, 45, 24, 0, -24, -45, -59, -64, -59, -45, -24};

    quad_anim_if bus ();

    quad_anim #(.HALF(24), .VX0(2), .VY0(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic corners_t pts(input int ax, ay, bx, by, cx, cy, dx, dy);
        corners_t c;
        c.ax = ax; c.ay = ay; c.bx = bx; c.by = by;
        c.cx = cx; c.cy = cy; c.dx = dx; c.dy = dy;
        return c;
    endfunction

    function automatic corners_t model_corners();
        int p  = HALF * cos_t[mph];
        int q  = HALF * sin_t[mph];
        int ex = (q - p) >>> 6;
        int ey = (-q - p) >>> 6;
        return pts(mcx + ex, mcy + ey, mcx + ey, mcy - ex,
                   mcx - ex, mcy - ey, mcx - ey, mcy + ex);
    endfunction

    task automatic model_reset();
        mcx = H / 2; mcy = V / 2; mvx = 2; mvy = 1; mph = 0;
        exp_q.delete();
        last_exp = pts(296, 216, 296, 264, 344, 264, 344, 216);
    endtask

    task automatic model_step();
        int nx = mcx + mvx;
        int ny = mcy + mvy;
        if (nx > H - 1 - M) begin mcx = H - 1 - M; mvx = -mvx; end
        else if (nx < M)    begin mcx = M;         mvx = -mvx; end
        else                      mcx = nx;
        if (ny > V - 1 - M) begin mcy = V - 1 - M; mvy = -mvy; end
        else if (ny < M)    begin mcy = M;         mvy = -mvy; end
        else                      mcy = ny;
        mph = (mph + 1) % 16;
    endtask

    task automatic check_pts(input string tag, input corners_t e);
        check($sformatf("%s a.x", tag), int'(bus.pointax), e.ax);
        check($sformatf("%s a.y", tag), int'(bus.pointay), e.ay);
        check($sformatf("%s b.x", tag), int'(bus.pointbx), e.bx);
        check($sformatf("%s b.y", tag), int'(bus.pointby), e.by);
        check($sformatf("%s c.x", tag), int'(bus.pointcx), e.cx);
        check($sformatf("%s c.y", tag), int'(bus.pointcy), e.cy);
        check($sformatf("%s d.x", tag), int'(bus.pointdx), e.dx);
        check($sformatf("%s d.y", tag), int'(bus.pointdy), e.dy);
    endtask

    // Monitor: every frame_done must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && bus.frame_done) begin
            if (exp_q.size() == 0) check("frame_done without tick", int'(bus.frame_done), 0);
            else                   check_pts("frame", exp_q.pop_front());
        end
    end

    // One frame: tick cycle, wait for the commit, then scan the active area.
    task automatic do_tick(input bit paused);
        int n        = 1;
        int busy_any = 0;
        int hold_bad = 0;
        @(negedge clk);
        bus.pause   = paused;
        bus.h_count = 10'd0;
        bus.v_count = 10'd480;
        if (!paused) begin
            model_step();
            last_exp = model_corners();
            exp_q.push_back(last_exp);
        end
        @(posedge clk); #1;
        bus.h_count = 10'd3;
        bus.v_count = 10'd482;
        busy_any |= int'(bus.busy);
        while (!bus.frame_done && n < 10) begin
            @(posedge clk); #1;
            n++;
            busy_any |= int'(bus.busy);
        end
        if (paused) check("busy while paused", busy_any, 0);
        else        check("tick to frame_done latency", n, 6);
        repeat (4) begin
            @(negedge clk);
            bus.h_count = 10'($urandom_range(0, H - 1));
            bus.v_count = 10'($urandom_range(0, V - 1));
            @(posedge clk); #1;
            if (bus.pointax != last_exp.ax || bus.pointay != last_exp.ay ||
                bus.pointbx != last_exp.bx || bus.pointby != last_exp.by ||
                bus.pointcx != last_exp.cx || bus.pointcy != last_exp.cy ||
                bus.pointdx != last_exp.dx || bus.pointdy != last_exp.dy)
                hold_bad++;
        end
        check("corners held through active area", hold_bad, 0);
        bus.pause = 1'b0;
    endtask

    initial begin
        bus.pause   = 1'b0;
        bus.h_count = 10'd0;
        bus.v_count = 10'd0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_pts("reset", last_exp);
        check("reset busy", int'(bus.busy), 0);

        do_tick(1'b0);
        check_pts("first tick", pts(308, 209, 290, 255, 336, 273, 354, 227));

        repeat (3) do_tick(1'b1);
        check_pts("after pause", pts(308, 209, 290, 255, 336, 273, 354, 227));

        // Reset pulsed while the sequencer sits in MUL_S.
        @(negedge clk);
        bus.h_count = 10'd0;
        bus.v_count = 10'd480;
        @(posedge clk); #1;
        bus.h_count = 10'd3;
        bus.v_count = 10'd482;
        repeat (2) begin @(posedge clk); #1; end
        check("busy mid-computation", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_pts("async reset", last_exp);
        check("busy after async reset", int'(bus.busy), 0);
        check("frame_done after async reset", int'(bus.frame_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);

        for (int k = 1; k <= 143; k++) begin
            do_tick(1'b0);
            if (k == 1)
                check_pts("tick after reset", pts(308, 209, 290, 255, 336, 273, 354, 227));
            if (k == 16)
                check_pts("phase wrap", pts(328, 232, 328, 280, 376, 280, 376, 232));
            if (k == 142) begin
                check("centre x after 142", (int'(bus.pointax) + int'(bus.pointcx)) / 2, 603);
                check("centre y after 142", (int'(bus.pointay) + int'(bus.pointcy)) / 2, 382);
            end
            if (k == 143)
                check("centre x after 143", (int'(bus.pointax) + int'(bus.pointcx)) / 2, 601);
        end

        repeat (4) @(posedge clk);
        check("frames left outstanding", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
